// File: rtl/sm_pkg.sv
// Shared types for the sequential-multiplier issue controller.
package sm_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;

    typedef struct packed {
        logic [OP_W-1:0] multiplicand;
        logic [OP_W-1:0] multiplier;
    } sm_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_HOLD
    } sm_state_t;

endpackage

// File: rtl/sm_op_fifo.sv
// Operand-pair FIFO: power-of-two depth, registered occupancy, no push/pop bypass.
module sm_op_fifo
    import sm_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  sm_op_t push_data,
    input  logic   pop,
    output sm_op_t head,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    sm_op_t           mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Full is judged on the registered count, so a pop cannot make room for a same-cycle push.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sm_issue_ctrl.sv
// Issue/collect sequencer for the 16x16 sequential multiplier.
// Optional watchdog and sticky err_timeout port: define SM_CTRL_TIMEOUT_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a queued operand pair; pops it onto sm_* operands
// ST_ISSUE   | sm_start high for this single cycle
// ST_WAIT_LO | waiting for sm_ready to drop (ignores a stale done)
// ST_WAIT_HI | waiting for sm_ready to rise; captures if result reg is free
// ST_HOLD    | product ready but result reg occupied; capture once it frees
module sm_issue_ctrl
    import sm_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     in_multiplicand,
    input  logic [OP_W-1:0]     in_multiplier,
    output logic                sm_start,
    output logic [OP_W-1:0]     sm_multiplicand,
    output logic [OP_W-1:0]     sm_multiplier,
    input  logic [PROD_W-1:0]   sm_product,
    input  logic                sm_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [PROD_W-1:0]   res_product,
    output logic                busy
`ifdef SM_CTRL_TIMEOUT_EN
    ,
    output logic                err_timeout
`endif
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_err
        $error("sm_issue_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
    end

    sm_state_t state;
    sm_op_t    fifo_in;
    sm_op_t    fifo_head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_pop;
    logic      res_free;

    assign fifo_in  = '{multiplicand: in_multiplicand, multiplier: in_multiplier};
    assign in_ready = !fifo_full;
    assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
    assign busy     = (state != ST_IDLE) || !fifo_empty;
    // The result register can take a new product if empty or being drained this cycle.
    assign res_free = !res_valid || res_ready;

    sm_op_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_op_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef SM_CTRL_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] tmr;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            sm_start        <= 1'b0;
            sm_multiplicand <= '0;
            sm_multiplier   <= '0;
            res_valid       <= 1'b0;
            res_product     <= '0;
`ifdef SM_CTRL_TIMEOUT_EN
            tmr             <= '0;
            err_timeout     <= 1'b0;
`endif
        end else begin
            sm_start <= 1'b0;
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
`ifdef SM_CTRL_TIMEOUT_EN
            // Down-counter: expires after TIMEOUT_CYCLES cycles spent in the wait states.
            if ((state == ST_WAIT_LO || state == ST_WAIT_HI) && tmr != '0) begin
                tmr <= tmr - 1'b1;
            end
`endif
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        sm_multiplicand <= fifo_head.multiplicand;
                        sm_multiplier   <= fifo_head.multiplier;
                        sm_start        <= 1'b1;
                        state           <= ST_ISSUE;
`ifdef SM_CTRL_TIMEOUT_EN
                        tmr             <= TMR_LOAD;
`endif
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (!sm_ready) begin
                        state <= ST_WAIT_HI;
                    end
`ifdef SM_CTRL_TIMEOUT_EN
                    else if (tmr == '0) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
`endif
                end
                ST_WAIT_HI: begin
                    if (sm_ready) begin
                        if (res_free) begin
                            res_product <= sm_product;
                            res_valid   <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
`ifdef SM_CTRL_TIMEOUT_EN
                    else if (tmr == '0) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
`endif
                end
                ST_HOLD: begin
                    if (res_free) begin
                        res_product <= sm_product;
                        res_valid   <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_issue_ctrl.sv
// Self-checking bench for sm_issue_ctrl: behavioural SM model plus in-order result scoreboard.
module tb_sm_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_multiplicand;
    logic [15:0] in_multiplier;
    logic        sm_start;
    logic [15:0] sm_multiplicand;
    logic [15:0] sm_multiplier;
    logic [31:0] sm_product;
    logic        sm_ready;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_product;
    logic        busy;
`ifdef SM_CTRL_TIMEOUT_EN
    logic        err_timeout;
`endif

    sm_issue_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_multiplicand (in_multiplicand),
        .in_multiplier   (in_multiplier),
        .sm_start        (sm_start),
        .sm_multiplicand (sm_multiplicand),
        .sm_multiplier   (sm_multiplier),
        .sm_product      (sm_product),
        .sm_ready        (sm_ready),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_product     (res_product),
        .busy            (busy)
`ifdef SM_CTRL_TIMEOUT_EN
        ,
        .err_timeout     (err_timeout)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] iss_q [$];
    logic [31:0] exp_q [$];
    int          sm_cnt = 0;
    int          sm_pend = 0;
    int          sm_lat_fix = 3;
    int          sm_react = 0;
    bit          sm_hang = 1'b0;
    logic [15:0] pa = '0;
    logic [15:0] pb = '0;
    bit          prev_start = 1'b0;
    int          n_res = 0;
    bit          rnd_rr = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SM model: reacts to start after 1..2 negedges, then holds ready low for lat cycles.
    initial begin
        sm_ready   = 1'b1;
        sm_product = 32'hA5A5_5A5A;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_start = 1'b0;
            end else begin
                if (sm_start) begin
                    check_val("start_width", 64'(prev_start), 64'(0));
                end
                prev_start = sm_start;
                if (sm_pend > 0) begin
                    sm_pend--;
                    if (sm_pend == 0) begin
                        sm_ready   = 1'b0;
                        sm_product = $urandom();
                        sm_cnt     = sm_hang ? 0 : ((sm_lat_fix > 0) ? sm_lat_fix : int'($urandom_range(1, 8)));
                    end
                end else if (sm_cnt > 0) begin
                    sm_cnt--;
                    if (sm_cnt == 0) begin
                        check_val("ops_stable", 64'({sm_multiplicand, sm_multiplier}), 64'({pa, pb}));
                        sm_product = 32'(pa) * 32'(pb);
                        sm_ready   = 1'b1;
                    end
                end else if (sm_start) begin
                    if (iss_q.size() == 0) begin
                        check_val("issue_spurious", 64'(iss_q.size()), 64'(1));
                    end else begin
                        check_val("issue_ops", 64'({sm_multiplicand, sm_multiplier}), 64'(iss_q.pop_front()));
                    end
                    pa      = sm_multiplicand;
                    pb      = sm_multiplier;
                    sm_pend = 1 + ((sm_react < 0) ? int'($urandom_range(0, 1)) : sm_react);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset && res_valid && res_ready) begin
                n_res++;
                if (exp_q.size() == 0) begin
                    check_val("res_spurious", 64'(exp_q.size()), 64'(1));
                end else begin
                    check_val("res_product", 64'(res_product), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rnd_rr) res_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        bit ok = 1'b0;
        in_valid        = 1'b1;
        in_multiplicand = a;
        in_multiplier   = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = in_ready;
            @(posedge clk);
            if (ok) begin
                iss_q.push_back({a, b});
                exp_q.push_back(32'(a) * 32'(b));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) check_val("push_timeout", 64'(in_ready), 64'(1));
    endtask

    task automatic wait_res_valid(input int max);
        int i = 0;
        while (!res_valid && i < max) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (!res_valid) check_val("res_timeout", 64'(res_valid), 64'(1));
    endtask

    task automatic wait_drain(input int max);
        int i = 0;
        while ((exp_q.size() != 0 || busy || res_valid) && i < max) begin
            @(negedge clk);
            #1;
            i++;
        end
        check_val("drain_left", 64'(exp_q.size()), 64'(0));
        check_val("drain_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        int r0;
        int k;
        logic [15:0] a;
        logic [15:0] b;
        reset           = 1'b1;
        in_valid        = 1'b0;
        in_multiplicand = '0;
        in_multiplier   = '0;
        res_ready       = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_in_ready", 64'(in_ready), 64'(1));
        check_val("rst_res_valid", 64'(res_valid), 64'(0));
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_sm_start", 64'(sm_start), 64'(0));
        check_val("rst_sm_ops", 64'({sm_multiplicand, sm_multiplier}), 64'(0));
        check_val("rst_res_product", 64'(res_product), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // 3 x 5, start pulse timing and single-cycle res_valid
        sm_lat_fix = 3;
        sm_react   = 0;
        res_ready  = 1'b1;
        push(16'h0003, 16'h0005);
        #1;
        check_val("lat_cycle1", 64'(sm_start), 64'(0));
        @(negedge clk); #1;
        check_val("lat_cycle2", 64'(sm_start), 64'(1));
        @(negedge clk); #1;
        check_val("start_once", 64'(sm_start), 64'(0));
        wait_res_valid(50);
        check_val("t1_prod", 64'(res_product), 64'(32'h0000_000F));
        @(negedge clk); #1;
        check_val("t1_pulse", 64'(res_valid), 64'(0));

        // Full-scale operands
        push(16'hFFFF, 16'hFFFF);
        wait_res_valid(50);
        check_val("t2_prod", 64'(res_product), 64'(32'hFFFE_0001));
        wait_drain(100);

        // Back-pressure: five pairs with consumer stalled
        res_ready  = 1'b0;
        sm_lat_fix = 5;
        for (int i = 0; i < 5; i++) begin
            push(16'(16'h0100 + i), 16'(i + 7));
        end
        #1;
        check_val("t3_full", 64'(in_ready), 64'(0));
        repeat (60) @(negedge clk);
        #1;
        check_val("t3_res_valid", 64'(res_valid), 64'(1));
        check_val("t3_held", 64'(res_product), 64'(exp_q[0]));
        check_val("t3_busy", 64'(busy), 64'(1));
        check_val("t3_room", 64'(in_ready), 64'(1));
        @(negedge clk);
        res_ready = 1'b1;
        wait_drain(400);

        // Stale ready: SM idles with ready high and an old product
        sm_react   = 1;
        sm_lat_fix = 4;
        sm_product = 32'hDEAD_BEEF;
        push(16'h1234, 16'h0002);
        wait_res_valid(50);
        check_val("t4_prod", 64'(res_product), 64'(32'h0000_2468));
        wait_drain(100);

        // Reset mid-operation with two pairs still queued
        sm_react   = 0;
        sm_lat_fix = 8;
        push(16'h0011, 16'h0022);
        push(16'h0033, 16'h0044);
        push(16'h0055, 16'h0066);
        k = 0;
        while (!(sm_cnt > 0 && sm_cnt <= 3) && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        check_val("t5_reached_wait", 64'(sm_cnt > 0 && sm_cnt <= 3), 64'(1));
        reset = 1'b1;
        #1;
        check_val("t5_res_valid", 64'(res_valid), 64'(0));
        check_val("t5_in_ready", 64'(in_ready), 64'(1));
        check_val("t5_busy", 64'(busy), 64'(0));
        check_val("t5_sm_start", 64'(sm_start), 64'(0));
        iss_q.delete();
        exp_q.delete();
        sm_cnt   = 0;
        sm_pend  = 0;
        sm_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        r0 = n_res;
        repeat (30) @(negedge clk);
        #1;
        check_val("t5_no_result", 64'(n_res - r0), 64'(0));
        check_val("t5_idle", 64'(busy), 64'(0));

`ifdef SM_CTRL_TIMEOUT_EN
        // SM never completes: watchdog abandons the op, next pair proceeds
        sm_hang  = 1'b1;
        sm_react = 0;
        push(16'h0007, 16'h0009);
        push(16'h000A, 16'h000B);
        k = 0;
        while (!sm_start && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        check_val("to_started", 64'(sm_start), 64'(1));
        repeat (64) @(negedge clk);
        #1;
        check_val("to_not_yet", 64'(err_timeout), 64'(0));
        @(negedge clk); #1;
        check_val("to_err", 64'(err_timeout), 64'(1));
        sm_hang = 1'b0;
        void'(exp_q.pop_front());
        wait_drain(200);
        check_val("to_sticky", 64'(err_timeout), 64'(1));
`endif

        // Randomized traffic with random consumer stalls and SM timing
        sm_lat_fix = 0;
        sm_react   = -1;
        rnd_rr     = 1'b1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            case ($urandom_range(0, 5))
                0:       begin a = 16'hFFFF; b = 16'($urandom); end
                1:       begin a = 16'($urandom); b = 16'h0000; end
                default: begin a = 16'($urandom); b = 16'($urandom); end
            endcase
            push(a, b);
        end
        rnd_rr = 1'b0;
        @(negedge clk);
        res_ready = 1'b1;
        wait_drain(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
